// File: rtl/gt_victim_cache.sv
// Fully associative victim cache behind the L1: tree-PLRU replacement, whole-line
// lookups with byte select, and a single-slot handshaked write-back register.
module gt_victim_cache #(
    parameter int ENTRIES    = 4,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32,
    parameter int EXCLUSIVE  = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    lkValid,
    input  logic [ADDR_W-1:0]       lkAddr,
    output logic                    rspValid,
    output logic                    hit,
    output logic [7:0]              dataReturn,
    output logic [8*LINE_BYTES-1:0] memDataOut,
    input  logic                    insValid,
    input  logic [ADDR_W-1:0]       insAddr,
    input  logic [8*LINE_BYTES-1:0] insData,
    output logic                    insReady,
    output logic                    wbValid,
    output logic [ADDR_W-1:0]       wbAddr,
    output logic [8*LINE_BYTES-1:0] toMemData,
    input  logic                    wbReady
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = ADDR_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int PL_W   = ENTRIES - 1;
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int NODE_W = IDX_W + 1;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [ENTRIES];
    logic [LINE_W-1:0]  r_data [ENTRIES];
    logic [PL_W-1:0]    r_plru;
    logic               r_rsp_valid;
    logic               r_hit;
    logic [7:0]         r_byte;
    logic [LINE_W-1:0]  r_line;
    logic               r_wb_valid;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [LINE_W-1:0]  r_wb_data;

    logic [TAG_W-1:0]   w_lk_tag;
    logic [TAG_W-1:0]   w_ins_tag;
    logic [OFF_W-1:0]   w_lk_off;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_lk_idx;
    logic               w_ins_hit;
    logic [IDX_W-1:0]   w_ins_hit_idx;
    logic               w_any_inv;
    logic [IDX_W-1:0]   w_inv_idx;
    logic [IDX_W-1:0]   w_victim;
    logic [IDX_W-1:0]   w_target;
    logic               w_lk_fire;
    logic               w_ins_fire;
    logic               w_evict;
    logic               w_lk_inval;
    logic [PL_W-1:0]    w_plru_next;
    logic [LINE_W-1:0]  w_hit_line;
    logic [7:0]         w_hit_byte;
    logic               w_unused_ins_off;

    // Point every node on the leaf-to-root path of entry e away from e.
    function automatic logic [PL_W-1:0] f_touch(input logic [PL_W-1:0] p,
                                                input logic [IDX_W-1:0] e);
        logic [PL_W-1:0]   q;
        logic [NODE_W-1:0] n;
        logic [NODE_W-1:0] par;
        q = p;
        n = {1'b0, e} + NODE_W'(PL_W);
        for (int l = 0; l < IDX_W; l++) begin
            par = (n - NODE_W'(1)) >> 1;
            for (int k = 0; k < PL_W; k++) begin
                if (par == NODE_W'(k)) q[k] = n[0];
            end
            n = par;
        end
        return q;
    endfunction

    assign w_lk_tag         = lkAddr[ADDR_W-1:OFF_W];
    assign w_lk_off         = lkAddr[OFF_W-1:0];
    assign w_ins_tag        = insAddr[ADDR_W-1:OFF_W];
    assign w_unused_ins_off = ^insAddr[OFF_W-1:0];

    // Downward scan so the lowest matching / invalid index wins.
    always_comb begin
        w_lk_hit      = 1'b0;
        w_lk_idx      = '0;
        w_ins_hit     = 1'b0;
        w_ins_hit_idx = '0;
        w_any_inv     = 1'b0;
        w_inv_idx     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = IDX_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == w_ins_tag)) begin
                w_ins_hit     = 1'b1;
                w_ins_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_any_inv = 1'b1;
                w_inv_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        logic [NODE_W-1:0] n;
        logic              b;
        n = '0;
        for (int l = 0; l < IDX_W; l++) begin
            b = 1'b0;
            for (int k = 0; k < PL_W; k++) begin
                if (n == NODE_W'(k)) b = r_plru[k];
            end
            n = (n << 1) + NODE_W'(1) + NODE_W'(b);
        end
        w_victim = IDX_W'(n - NODE_W'(PL_W));
    end

    assign insReady   = !r_wb_valid || wbReady;
    assign w_ins_fire = insValid && insReady;
    assign w_lk_fire  = lkValid && w_lk_hit;
    assign w_target   = w_ins_hit ? w_ins_hit_idx : (w_any_inv ? w_inv_idx : w_victim);
    assign w_evict    = w_ins_fire && !w_ins_hit && !w_any_inv;
    // An insert landing on the hit entry overrides the exclusive invalidation.
    assign w_lk_inval = w_lk_fire && (EXCLUSIVE != 0) && !(w_ins_fire && (w_target == w_lk_idx));
    assign w_hit_line = r_data[w_lk_idx];
    assign w_hit_byte = w_hit_line[{w_lk_off, 3'b000} +: 8];

    always_comb begin
        w_plru_next = r_plru;
        if (w_lk_fire)  w_plru_next = f_touch(w_plru_next, w_lk_idx);
        if (w_ins_fire) w_plru_next = f_touch(w_plru_next, w_target);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid     <= '0;
            r_plru      <= '0;
            r_rsp_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_byte      <= '0;
            r_line      <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
        end else begin
            r_rsp_valid <= lkValid;
            r_hit       <= w_lk_fire;
            if (w_lk_fire) begin
                r_line <= w_hit_line;
                r_byte <= w_hit_byte;
            end
            r_plru <= w_plru_next;
            if (w_lk_inval) r_valid[w_lk_idx] <= 1'b0;
            if (w_ins_fire) r_valid[w_target] <= 1'b1;
            if (w_evict) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= {r_tag[w_victim], {OFF_W{1'b0}}};
                r_wb_data  <= r_data[w_victim];
            end else if (wbReady) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ins_fire) begin
            r_tag[w_target]  <= w_ins_tag;
            r_data[w_target] <= insData;
        end
    end

    assign rspValid   = r_rsp_valid;
    assign hit        = r_hit;
    assign dataReturn = r_byte;
    assign memDataOut = r_line;
    assign wbValid    = r_wb_valid;
    assign wbAddr     = r_wb_addr;
    assign toMemData  = r_wb_data;
endmodule

// File: tb/tb_gt_victim_cache.sv
// Scoreboard bench for gt_victim_cache: instance 0 is non-exclusive, instance 1 exclusive.
module tb_gt_victim_cache;
    localparam int LB = 32;
    localparam int LW = 256;
    localparam int AW = 32;

    typedef struct packed {
        logic          hit;
        logic [7:0]    b;
        logic [LW-1:0] line;
    } rsp_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } wb_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          lkValid    [2];
    logic [AW-1:0] lkAddr     [2];
    logic          rspValid   [2];
    logic          hit        [2];
    logic [7:0]    dataReturn [2];
    logic [LW-1:0] memDataOut [2];
    logic          insValid   [2];
    logic [AW-1:0] insAddr    [2];
    logic [LW-1:0] insData    [2];
    logic          insReady   [2];
    logic          wbValid    [2];
    logic [AW-1:0] wbAddr     [2];
    logic [LW-1:0] toMemData  [2];
    logic          wbReady    [2];

    rsp_t rq0[$];
    rsp_t rq1[$];
    wb_t  wq0[$];
    wb_t  wq1[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    gt_victim_cache #(.ENTRIES(4), .LINE_BYTES(LB), .ADDR_W(AW), .EXCLUSIVE(0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .lkValid(lkValid[0]), .lkAddr(lkAddr[0]), .rspValid(rspValid[0]), .hit(hit[0]),
        .dataReturn(dataReturn[0]), .memDataOut(memDataOut[0]),
        .insValid(insValid[0]), .insAddr(insAddr[0]), .insData(insData[0]), .insReady(insReady[0]),
        .wbValid(wbValid[0]), .wbAddr(wbAddr[0]), .toMemData(toMemData[0]), .wbReady(wbReady[0]));

    gt_victim_cache #(.ENTRIES(4), .LINE_BYTES(LB), .ADDR_W(AW), .EXCLUSIVE(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .lkValid(lkValid[1]), .lkAddr(lkAddr[1]), .rspValid(rspValid[1]), .hit(hit[1]),
        .dataReturn(dataReturn[1]), .memDataOut(memDataOut[1]),
        .insValid(insValid[1]), .insAddr(insAddr[1]), .insData(insData[1]), .insReady(insReady[1]),
        .wbValid(wbValid[1]), .wbAddr(wbAddr[1]), .toMemData(toMemData[1]), .wbReady(wbReady[1]));

    function automatic logic [LW-1:0] mk_line(input logic [7:0] s);
        logic [LW-1:0] l;
        for (int i = 0; i < LB; i++) l[8*i +: 8] = s + 8'(i);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
    endtask

    // Lookup; expected byte is the line seed plus the byte offset.
    task automatic lk(input int d, input logic [AW-1:0] a, input logic eh, input logic [7:0] s);
        rsp_t e;
        e.hit  = eh;
        e.b    = s + {3'b000, a[4:0]};
        e.line = mk_line(s);
        if (d == 0) rq0.push_back(e);
        else        rq1.push_back(e);
        lkValid[d] = 1'b1;
        lkAddr[d]  = a;
        idle();
        lkValid[d] = 1'b0;
    endtask

    task automatic ins(input int d, input logic [AW-1:0] a, input logic [7:0] s,
                       input logic ewb, input logic [AW-1:0] wa, input logic [7:0] ws);
        wb_t w;
        int  t;
        insValid[d] = 1'b1;
        insAddr[d]  = a;
        insData[d]  = mk_line(s);
        #1;
        t = 0;
        while (!insReady[d] && t < 20) begin
            idle();
            t++;
        end
        chk("ins_ready_wait", LW'(insReady[d]), LW'(1'b1));
        if (ewb) begin
            w.a = wa;
            w.d = mk_line(ws);
            if (d == 0) wq0.push_back(w);
            else        wq1.push_back(w);
        end
        @(posedge CLK);
        #1;
        insValid[d] = 1'b0;
    endtask

    task automatic chk_zero(input int d);
        chk($sformatf("rst_rspValid%0d", d), LW'(rspValid[d]), '0);
        chk($sformatf("rst_hit%0d", d), LW'(hit[d]), '0);
        chk($sformatf("rst_dataReturn%0d", d), LW'(dataReturn[d]), '0);
        chk($sformatf("rst_memDataOut%0d", d), memDataOut[d], '0);
        chk($sformatf("rst_wbValid%0d", d), LW'(wbValid[d]), '0);
        chk($sformatf("rst_wbAddr%0d", d), LW'(wbAddr[d]), '0);
        chk($sformatf("rst_toMemData%0d", d), toMemData[d], '0);
        chk($sformatf("rst_insReady%0d", d), LW'(insReady[d]), LW'(1'b1));
    endtask

    always @(negedge CLK) begin
        rsp_t e;
        wb_t  w;
        logic got;
        for (int d = 0; d < 2; d++) begin
            if (RST_N && rspValid[d]) begin
                got = 1'b0;
                if (d == 0 && rq0.size() > 0) begin e = rq0.pop_front(); got = 1'b1; end
                else if (d == 1 && rq1.size() > 0) begin e = rq1.pop_front(); got = 1'b1; end
                if (!got) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rsp_unexpected dut%0d: got rspValid=1 expected none", d);
                end else begin
                    chk($sformatf("rsp_hit%0d", d), LW'(hit[d]), LW'(e.hit));
                    if (e.hit) begin
                        chk($sformatf("rsp_byte%0d", d), LW'(dataReturn[d]), LW'(e.b));
                        chk($sformatf("rsp_line%0d", d), memDataOut[d], e.line);
                    end
                end
            end
            if (RST_N && wbValid[d] && wbReady[d]) begin
                got = 1'b0;
                if (d == 0 && wq0.size() > 0) begin w = wq0.pop_front(); got = 1'b1; end
                else if (d == 1 && wq1.size() > 0) begin w = wq1.pop_front(); got = 1'b1; end
                if (!got) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected dut%0d: got wbAddr=%0h expected none", d, wbAddr[d]);
                end else begin
                    chk($sformatf("wb_addr%0d", d), LW'(wbAddr[d]), LW'(w.a));
                    chk($sformatf("wb_data%0d", d), toMemData[d], w.d);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            lkValid[d]  = 1'b0;
            lkAddr[d]   = '0;
            insValid[d] = 1'b0;
            insAddr[d]  = '0;
            insData[d]  = '0;
            wbReady[d]  = 1'b1;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk_zero(0);
        chk_zero(1);
        RST_N = 1'b1;
        idle();

        // Exclusive instance: fill, evict A, exclusive hit, duplicate insert.
        ins(1, 32'h1000, 8'h55, 0, '0, '0);
        ins(1, 32'h2000, 8'h40, 0, '0, '0);
        ins(1, 32'h3000, 8'h80, 0, '0, '0);
        ins(1, 32'h4000, 8'hC0, 0, '0, '0);
        ins(1, 32'h5000, 8'h00, 1, 32'h1000, 8'h55);
        chk("evict_wbValid", LW'(wbValid[1]), LW'(1'b1));
        lk(1, 32'h1004, 0, 8'h00);
        lk(1, 32'h201F, 1, 8'h40);
        lk(1, 32'h2000, 0, 8'h00);
        ins(1, 32'h6000, 8'h33, 0, '0, '0);
        chk("refill_no_wb", LW'(wbValid[1]), '0);
        lk(1, 32'h6002, 1, 8'h33);
        ins(1, 32'h3007, 8'h99, 0, '0, '0);
        chk("dup_no_wb", LW'(wbValid[1]), '0);
        lk(1, 32'h3008, 1, 8'h99);
        lk(1, 32'h3000, 0, 8'h00);
        lk(1, 32'h4000, 1, 8'hC0);
        lk(1, 32'h5001, 1, 8'h00);

        // Non-exclusive instance: byte select, PLRU after hit, back-pressure.
        ins(0, 32'h1000, 8'h00, 0, '0, '0);
        ins(0, 32'h2000, 8'h40, 0, '0, '0);
        ins(0, 32'h3000, 8'h80, 0, '0, '0);
        ins(0, 32'h4000, 8'hC0, 0, '0, '0);
        lk(0, 32'h1013, 1, 8'h00);
        chk("lat_rspValid", LW'(rspValid[0]), LW'(1'b1));
        chk("lat_dataReturn", LW'(dataReturn[0]), LW'(8'h13));
        idle();
        chk("pulse_rspValid", LW'(rspValid[0]), '0);
        // Touching A points the root right, so the walk lands on entry 2 (C).
        wbReady[0] = 1'b0;
        ins(0, 32'h5000, 8'h10, 1, 32'h3000, 8'h80);
        chk("bp_wbValid", LW'(wbValid[0]), LW'(1'b1));
        chk("bp_insReady", LW'(insReady[0]), '0);
        chk("bp_wbAddr", LW'(wbAddr[0]), LW'(32'h3000));
        insValid[0] = 1'b1;
        insAddr[0]  = 32'h6000;
        insData[0]  = mk_line(8'h22);
        for (int c = 0; c < 2; c++) begin
            idle();
            chk("stall_insReady", LW'(insReady[0]), '0);
            chk("stall_wbAddr", LW'(wbAddr[0]), LW'(32'h3000));
        end
        begin
            wb_t w;
            w.a = 32'h2000;
            w.d = mk_line(8'h40);
            wq0.push_back(w);
        end
        wbReady[0] = 1'b1;
        #1;
        chk("release_insReady", LW'(insReady[0]), LW'(1'b1));
        @(posedge CLK);
        #1;
        insValid[0] = 1'b0;
        chk("chain_wbValid", LW'(wbValid[0]), LW'(1'b1));
        chk("chain_wbAddr", LW'(wbAddr[0]), LW'(32'h2000));
        idle();
        chk("drain_wbValid", LW'(wbValid[0]), '0);
        lk(0, 32'h3000, 0, 8'h00);
        lk(0, 32'h2000, 0, 8'h00);
        lk(0, 32'h5004, 1, 8'h10);
        lk(0, 32'h6007, 1, 8'h22);
        lk(0, 32'h101F, 1, 8'h00);
        lk(0, 32'h4000, 1, 8'hC0);

        // Asynchronous reset while a write-back is pending and a response is out.
        wbReady[0] = 1'b0;
        ins(0, 32'h7000, 8'h01, 0, '0, '0);
        chk("pre_rst_wbValid", LW'(wbValid[0]), LW'(1'b1));
        lkValid[0] = 1'b1;
        lkAddr[0]  = 32'h1000;
        @(posedge CLK);
        #3;
        lkValid[0] = 1'b0;
        RST_N = 1'b0;
        #1;
        chk_zero(0);
        @(posedge CLK);
        #1;
        RST_N      = 1'b1;
        wbReady[0] = 1'b1;
        idle();
        lk(0, 32'h1000, 0, 8'h00);
        lk(0, 32'h7000, 0, 8'h00);
        lk(1, 32'h4000, 0, 8'h00);
        repeat (3) idle();
        chk("rq0_left", LW'(rq0.size()), '0);
        chk("rq1_left", LW'(rq1.size()), '0);
        chk("wq0_left", LW'(wq0.size()), '0);
        chk("wq1_left", LW'(wq1.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
